// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite row renderer.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam int unsigned SCREEN_W_DEFAULT = 640;

    typedef logic signed [11:0] screen_x_t;

    function automatic int unsigned rom_addr_width(input int unsigned imgs,
                                                   input int unsigned w,
                                                   input int unsigned h);
        return $clog2(imgs * w * h);
    endfunction

endpackage

// File: rtl/sprite_pipe_align.sv
// Delay line that carries each fetched column's valid flag and screen X
// alongside the ROM read, so they line up with rom_data.
module sprite_pipe_align
    import sprite_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      valid_in,
    input  screen_x_t x_in,
    output logic      valid_out,
    output screen_x_t x_out
);

    logic [DEPTH-1:0] valid_sr;
    screen_x_t        x_sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_sr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                x_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= valid_in;
            x_sr[0]     <= x_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                x_sr[i]     <= x_sr[i-1];
            end
        end
    end

    assign valid_out = valid_sr[DEPTH-1];
    assign x_out     = x_sr[DEPTH-1];

endmodule

// File: rtl/sprite_line_engine.sv
// Renders one row of one sprite into linebuffer writes with clipping and
// transparency keying. Define SPRITE_HFLIP_EN to enable horizontal mirroring.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W   = 32,
    parameter int unsigned SPRITE_H   = 32,
    parameter int unsigned NUM_IMGS   = 32,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEFAULT,
    parameter int unsigned PIXEL_W    = 16,
    parameter int unsigned TRANSP_BIT = 0,
    parameter int unsigned ROM_LAT    = 1,
    localparam int unsigned IMG_W     = $clog2(NUM_IMGS),
    localparam int unsigned ROW_W     = $clog2(SPRITE_H),
    localparam int unsigned ADDR_W    = rom_addr_width(NUM_IMGS, SPRITE_W, SPRITE_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IMG_W-1:0]    img_num,
    input  logic [ROW_W-1:0]    row_in_sprite,
    input  logic signed [10:0]  sprite_x,
    input  logic                flip_h,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PIXEL_W-1:0]  rom_data,
    output logic                wren,
    output logic [9:0]          pixel_hcount,
    output logic [PIXEL_W-1:0]  data,
    output logic                busy,
    output logic                done
);

    localparam int unsigned COL_W = $clog2(SPRITE_W);
    localparam int unsigned DRN_W = 2;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(ROM_LAT - 1);

`ifdef SPRITE_HFLIP_EN
    localparam bit HFLIP_EN = 1'b1;
`else
    localparam bit HFLIP_EN = 1'b0;
`endif

    state_t           state;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_nxt;
    logic [DRN_W-1:0] drn_cnt;
    logic [IMG_W-1:0] img_l;
    logic [ROW_W-1:0] row_l;
    screen_x_t        sx_l;
    logic             flip_l;
    logic             valid_s0;
    screen_x_t        x_s0;
    logic             valid_al;
    screen_x_t        x_al;

    // Mirroring only changes which ROM column is read; screen X always ascends.
    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [IMG_W-1:0] img,
                                                     input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] c,
                                                     input logic             flip);
        logic [COL_W-1:0] fc;
        fc = (HFLIP_EN && flip) ? (LAST_COL - c) : c;
        return ADDR_W'({img, row, fc});
    endfunction

    assign col_nxt = col + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            col      <= '0;
            drn_cnt  <= '0;
            img_l    <= '0;
            row_l    <= '0;
            sx_l     <= '0;
            flip_l   <= 1'b0;
            rom_addr <= '0;
            valid_s0 <= 1'b0;
            x_s0     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        col      <= '0;
                        img_l    <= img_num;
                        row_l    <= row_in_sprite;
                        sx_l     <= screen_x_t'(sprite_x);
                        flip_l   <= flip_h;
                        rom_addr <= fetch_addr(img_num, row_in_sprite, '0, flip_h);
                        valid_s0 <= 1'b1;
                        x_s0     <= screen_x_t'(sprite_x);
                    end
                end
                FETCH: begin
                    if (col == LAST_COL) begin
                        state    <= DRAIN;
                        valid_s0 <= 1'b0;
                        drn_cnt  <= '0;
                    end else begin
                        col      <= col_nxt;
                        rom_addr <= fetch_addr(img_l, row_l, col_nxt, flip_l);
                        x_s0     <= sx_l + screen_x_t'(col_nxt);
                    end
                end
                DRAIN: begin
                    if (drn_cnt == LAST_DRN) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drn_cnt <= drn_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sprite_pipe_align #(
        .DEPTH(ROM_LAT)
    ) u_align (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_s0),
        .x_in     (x_s0),
        .valid_out(valid_al),
        .x_out    (x_al)
    );

    always_comb begin
        wren = valid_al && !x_al[11] && ($unsigned(x_al) < 12'(SCREEN_W))
               && !rom_data[TRANSP_BIT];
        pixel_hcount = x_al[9:0];
        data = valid_al ? rom_data : '0;
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine: directed table plus randomized
// rows compared against a per-pixel reference model.
module tb_sprite_line_engine;

    localparam int SW = 32;
    localparam int SH = 32;
    localparam int LAT = 1;
    localparam int SCR = 640;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [4:0]         img_num;
    logic [4:0]         row_in_sprite;
    logic signed [10:0] sprite_x;
    logic               flip_h;
    logic [14:0]        rom_addr;
    logic [15:0]        rom_data = '0;
    logic               wren;
    logic [9:0]         pixel_hcount;
    logic [15:0]        data;
    logic               busy;
    logic               done;

    logic [15:0] rom [0:32767];

    int n_cmp = 0;
    int n_err = 0;

    int          exp_x[$];
    logic [15:0] exp_d[$];
    int          act_x[$];
    logic [15:0] act_d[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    sprite_line_engine #(
        .SPRITE_W  (SW),
        .SPRITE_H  (SH),
        .NUM_IMGS  (32),
        .SCREEN_W  (SCR),
        .PIXEL_W   (16),
        .TRANSP_BIT(0),
        .ROM_LAT   (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .img_num      (img_num),
        .row_in_sprite(row_in_sprite),
        .sprite_x     (sprite_x),
        .flip_h       (flip_h),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .wren         (wren),
        .pixel_hcount (pixel_hcount),
        .data         (data),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the sprite columns and keep every on-screen opaque pixel.
    function automatic void build_expected(input int img, input int row, input int sx,
                                           input bit flip);
        bit hflip;
`ifdef SPRITE_HFLIP_EN
        hflip = flip;
`else
        hflip = 1'b0 & flip;
`endif
        exp_x.delete();
        exp_d.delete();
        for (int c = 0; c < SW; c++) begin
            int          src;
            int          x;
            logic [15:0] w;
            src = hflip ? (SW - 1 - c) : c;
            x   = sx + c;
            w   = rom[img * SW * SH + row * SW + src];
            if (x >= 0 && x < SCR && w[0] == 1'b0) begin
                exp_x.push_back(x);
                exp_d.push_back(w);
            end
        end
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_txn(input string tag, input int img, input int row, input int sx,
                           input bit flip, input int pulse_at, output int first_addr);
        int done_at;
        int n;
        build_expected(img, row, sx, flip);
        act_x.delete();
        act_d.delete();
        start         = 1'b1;
        img_num       = 5'(img);
        row_in_sprite = 5'(row);
        sprite_x      = 11'(sx);
        flip_h        = flip;
        @(posedge clk);
        done_at    = -1;
        first_addr = -1;
        for (int c = 0; c < SW + LAT + 12 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start         = 1'b0;
                first_addr    = int'(rom_addr);
                check($sformatf("%s busy_after_start", tag), busy, 1);
                img_num       = 5'($urandom);
                row_in_sprite = 5'($urandom);
                sprite_x      = 11'($urandom);
                flip_h        = 1'($urandom);
            end
            if (c == pulse_at) start = 1'b1;
            else if (c == pulse_at + 1) start = 1'b0;
            if (wren) begin
                act_x.push_back(int'(pixel_hcount));
                act_d.push_back(data);
            end
            if (done) done_at = c;
        end
        start = 1'b0;
        check($sformatf("%s done_latency", tag), done_at, SW + LAT);
        check($sformatf("%s busy_at_done", tag), busy, 0);
        @(negedge clk);
        check($sformatf("%s done_one_cycle", tag), done, 0);
        check($sformatf("%s write_count", tag), act_x.size(), exp_x.size());
        n = (act_x.size() < exp_x.size()) ? act_x.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s hcount[%0d]", tag, i), act_x[i], exp_x[i]);
            check($sformatf("%s data[%0d]", tag, i), act_d[i], exp_d[i]);
        end
    endtask

    typedef struct {
        int img;
        int row;
        int sx;
        int pulse_at;
        int exp_addr;
        int exp_cnt;
        int exp_first;
        int exp_last;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   fa;
        bit   seen_done;
        bit   seen_wren;

        vecs[0] = '{2, 5, 100, -1, 2208, 32, 100, 131};
        vecs[1] = '{3, 0, -8, 5, 3072, 24, 0, 23};
        vecs[2] = '{0, 31, 620, -1, 992, 20, 620, 639};
        vecs[3] = '{1, 0, 50, 12, 1024, 30, 50, 81};
        vecs[4] = '{4, 1, 640, -1, 4128, 0, 0, 0};
        vecs[5] = '{5, 2, -32, -1, 5184, 0, 0, 0};
        vecs[6] = '{6, 3, -31, -1, 6240, 1, 0, 0};
        vecs[7] = '{31, 31, 608, 20, 32736, 32, 608, 639};

        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom) & 16'hFFFE;
        rom[1024 + 3][0] = 1'b1;
        rom[1024 + 4][0] = 1'b1;

        reset = 1'b1;
        start = 1'b0;
        img_num = '0;
        row_in_sprite = '0;
        sprite_x = '0;
        flip_h = 1'b0;
        repeat (2) @(negedge clk);
        check("reset wren", wren, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rom_addr", rom_addr, 0);
        check("reset hcount", pixel_hcount, 0);
        check("reset data", data, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_txn(tag, vecs[v].img, vecs[v].row, vecs[v].sx, 1'b0, vecs[v].pulse_at, fa);
            check({tag, " first_addr"}, fa, vecs[v].exp_addr);
            check({tag, " count"}, act_x.size(), vecs[v].exp_cnt);
            if (vecs[v].exp_cnt > 0 && act_x.size() > 0) begin
                check({tag, " first_hcount"}, act_x[0], vecs[v].exp_first);
                check({tag, " last_hcount"}, act_x[act_x.size()-1], vecs[v].exp_last);
            end
            if (v == 3) begin
                int hits;
                hits = 0;
                foreach (act_x[k]) if (act_x[k] == 53 || act_x[k] == 54) hits++;
                check("vec3 transparent_cols_written", hits, 0);
            end
        end

        // Reset in the middle of a fetch: everything drops, no done follows.
        start = 1'b1;
        img_num = 5'd7;
        row_in_sprite = 5'd7;
        sprite_x = 11'sd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midfetch wren_before_reset", wren, 1);
        reset = 1'b1;
        #1;
        check("midfetch reset wren", wren, 0);
        check("midfetch reset busy", busy, 0);
        check("midfetch reset done", done, 0);
        check("midfetch reset rom_addr", rom_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        seen_wren = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (wren) seen_wren = 1'b1;
        end
        check("after_reset no_done", seen_done, 0);
        check("after_reset no_wren", seen_wren, 0);
        check("after_reset busy", busy, 0);

`ifdef SPRITE_HFLIP_EN
        rom[0][0]  = 1'b0;
        rom[31][0] = 1'b0;
        run_txn("flip", 0, 0, 0, 1'b1, -1, fa);
        check("flip first_addr", fa, 31);
        if (act_d.size() == 32) begin
            check("flip hcount0 data", act_d[0], rom[31]);
            check("flip hcount31 data", act_d[31], rom[0]);
        end
`endif

        for (int i = 0; i < 32768; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[0] = ($urandom_range(0, 3) == 0);
            rom[i] = w;
        end
        for (int t = 0; t < 24; t++) begin
            int img;
            int row;
            int sx;
            int pulse;
            bit flip;
            img   = $urandom_range(0, 31);
            row   = $urandom_range(0, 31);
            sx    = $urandom_range(0, 740) - 40;
            flip  = 1'($urandom);
            pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
            run_txn($sformatf("rand%0d", t), img, row, sx, flip, pulse, fa);
`ifdef SPRITE_HFLIP_EN
            check($sformatf("rand%0d first_addr", t), fa,
                  img * SW * SH + row * SW + (flip ? SW - 1 : 0));
`else
            check($sformatf("rand%0d first_addr", t), fa, img * SW * SH + row * SW);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
